qeciphy_tx_comma_inserter: RTL

Transmit-side partner of the RX byte aligner. It drives the 32-bit transceiver TX data path, and emits the comma word 32'h000000BC on a fixed cadence of one comma per COMMA_PERIOD cycles. During training it fills every other slot with an idle word. After training and remote alignment it merges user data into the non-comma slots through a valid/ready handshake. The comma cadence is never broken, so the remote aligner's boundary check keeps passing in data mode.

---
 rtl/qeciphy_pkg.sv | 15 +
 rtl/qeciphy_tx_comma_inserter_if.sv | 12 +
 rtl/qeciphy_period_counter.sv | 38 +++
 rtl/qeciphy_tx_comma_inserter.sv | 115 +++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
// Constants and types shared by the QEC PHY transmit inserter and receive aligner.
package qeciphy_pkg;

  localparam int TX_DATA_W = 32;

  localparam logic [TX_DATA_W-1:0] COMMA_WORD = 32'h0000_00BC;
  localparam logic [TX_DATA_W-1:0] IDLE_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } tx_comma_fsm_t;

endpackage

// File: rtl/qeciphy_tx_comma_inserter_if.sv
// User payload stream into the TX comma inserter (valid/ready handshake).
interface qeciphy_tx_comma_inserter_if;
  import qeciphy_pkg::*;

  logic [TX_DATA_W-1:0] tx_tdata;
  logic                 tx_tvalid;
  logic                 tx_tready;

  modport master (output tx_tdata, output tx_tvalid, input  tx_tready);
  modport slave  (input  tx_tdata, input  tx_tvalid, output tx_tready);

endinterface

// File: rtl/qeciphy_period_counter.sv
// Wrapping 0..PERIOD-1 counter with synchronous clear and a slot flag on the last count.
module qeciphy_period_counter #(
  parameter  int PERIOD = 1024,
  localparam int CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             slot_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign slot_o  = (count_q == LAST);

endmodule

// File: rtl/qeciphy_tx_comma_inserter.sv
// TX comma inserter: fixed-cadence comma words, idle fill while training,
// and user payload merged into the non-comma slots once in DATA.
module qeciphy_tx_comma_inserter
  import qeciphy_pkg::*;
#(
  parameter int COMMA_PERIOD      = 1024,
  parameter int MIN_TRAIN_PERIODS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_train_req,
  input  logic                  i_remote_aligned,
  qeciphy_tx_comma_inserter_if.slave s_tx,
  output logic [TX_DATA_W-1:0]  o_tx_data,
  output logic                  o_tx_comma,
  output logic                  o_training,
  output logic                  o_data_mode
);

  localparam int PC_W = $clog2(COMMA_PERIOD);
  localparam int TC_W = $clog2(MIN_TRAIN_PERIODS + 1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(MIN_TRAIN_PERIODS);

  tx_comma_fsm_t        state_q, state_d;
  logic [TC_W-1:0]      tc_q, tc_d;
  logic [TX_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                 tx_comma_q, tx_comma_d;
  logic                 training_q, data_mode_q;
  logic [PC_W-1:0]      pc;
  logic                 slot;
  logic                 pc_clear;
  logic                 train_done;

  // Clearing on the way into IDLE as well keeps pc at 0 for every IDLE cycle,
  // so the first TRAIN cycle always starts a fresh period.
  assign pc_clear = (state_q == ST_IDLE) || (state_d == ST_IDLE);

  qeciphy_period_counter #(
    .PERIOD (COMMA_PERIOD)
  ) u_period_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (pc_clear),
    .en_i    (1'b1),
    .count_o (pc),
    .slot_o  (slot)
  );

  // tc at MIN-1 means this slot's comma completes the training quota.
  assign train_done = slot && (tc_q >= (TC_MAX - TC_W'(1))) &&
                      i_remote_aligned && !i_train_req;

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_TRAIN;
        ST_TRAIN: if (train_done) state_d = ST_DATA;
        ST_DATA:  if (i_train_req) state_d = ST_TRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tc_d = '0;
    if (state_q == ST_TRAIN) begin
      tc_d = tc_q;
      if (slot && (tc_q != TC_MAX)) tc_d = tc_q + TC_W'(1);
    end
  end

  // Disable suppresses the word immediately, including a comma due this cycle.
  always_comb begin
    tx_comma_d = i_enable && slot && (state_q != ST_IDLE);
    if (tx_comma_d) begin
      tx_data_d = COMMA_WORD;
    end else if (i_enable && (state_q == ST_DATA) && s_tx.tx_tvalid) begin
      tx_data_d = s_tx.tx_tdata;
    end else begin
      tx_data_d = IDLE_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tc_q        <= '0;
      tx_data_q   <= IDLE_WORD;
      tx_comma_q  <= 1'b0;
      training_q  <= 1'b0;
      data_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      tx_data_q   <= tx_data_d;
      tx_comma_q  <= tx_comma_d;
      training_q  <= (state_q == ST_TRAIN);
      data_mode_q <= (state_q == ST_DATA);
    end
  end

  assign s_tx.tx_tready = (state_q == ST_DATA) && !slot;
  assign o_tx_data      = tx_data_q;
  assign o_tx_comma     = tx_comma_q;
  assign o_training     = training_q;
  assign o_data_mode    = data_mode_q;

  a_pc_idle_zero: assert property (@(posedge clk) disable iff (rst)
                                   (state_q == ST_IDLE) |-> (pc == '0));

endmodule
